// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt entry / RTI sequencing FSM (optional RST_VECTOR_EN reset-vector fetch)
module int_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = 8'h01,
  parameter logic [ADDR_W-1:0] RST_VEC_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              rti_ex,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              copy_CCR,
  output logic              paste_CCR,
  output logic              stack_push,
  output logic [DATA_W-1:0] stack_wdata,
  output logic              stack_pop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_val,
  output logic              pipe_stall,
  output logic              pipe_flush,
  output logic              int_ack,
  output logic              in_isr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INT_PUSH = 3'd1,
    INT_VRD  = 3'd2,
    INT_VLD  = 3'd3,
    RTI_POP  = 3'd4,
    RTI_LD   = 3'd5
`ifdef RST_VECTOR_EN
    ,
    RST_VRD  = 3'd6,
    RST_VLD  = 3'd7
`endif
  } state_t;

`ifdef RST_VECTOR_EN
  localparam state_t RESET_STATE = RST_VRD;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, next_state;
  logic   pending;
  logic   int_req_d;
  logic   req_edge;

  assign req_edge = int_req & ~int_req_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= next_state;
  end

  // Request edge capture; a new edge wins over the clear on INT_PUSH entry
  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_d <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_d <= int_req;
      if (req_edge)                                      pending <= 1'b1;
      else if (next_state == INT_PUSH && state != INT_PUSH) pending <= 1'b0;
    end
  end

  // Handler-active flag: set when the ISR vector is loaded, cleared when RTI reloads the PC
  always_ff @(posedge clk) begin
    if (rst)                  in_isr <= 1'b0;
    else if (state == INT_VLD) in_isr <= 1'b1;
    else if (state == RTI_LD)  in_isr <= 1'b0;
  end

  // Next-state selection; RTI takes priority over a pending interrupt
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rti_ex)                  next_state = RTI_POP;
        else if (pending && !in_isr) next_state = INT_PUSH;
      end
      INT_PUSH: next_state = INT_VRD;
      INT_VRD:  next_state = INT_VLD;
      INT_VLD:  next_state = IDLE;
      RTI_POP:  next_state = RTI_LD;
      RTI_LD:   next_state = IDLE;
`ifdef RST_VECTOR_EN
      RST_VRD:  next_state = RST_VLD;
      RST_VLD:  next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    copy_CCR    = 1'b0;
    paste_CCR   = 1'b0;
    stack_push  = 1'b0;
    stack_wdata = '0;
    stack_pop   = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    pipe_stall  = 1'b0;
    pipe_flush  = 1'b0;
    int_ack     = 1'b0;
    case (state)
      INT_PUSH: begin
        stack_push  = 1'b1;
        stack_wdata = pc_next;
        copy_CCR    = 1'b1;
        pipe_flush  = 1'b1;
        pipe_stall  = 1'b1;
        int_ack     = 1'b1;
      end
      INT_VRD: begin
        mem_rd     = 1'b1;
        mem_addr   = INT_VEC_ADDR;
        pipe_stall = 1'b1;
      end
      INT_VLD: begin
        pc_load     = 1'b1;
        pc_load_val = mem_rdata;
        pipe_stall  = 1'b1;
      end
      RTI_POP: begin
        stack_pop  = 1'b1;
        pipe_flush = 1'b1;
        pipe_stall = 1'b1;
      end
      RTI_LD: begin
        pc_load     = 1'b1;
        pc_load_val = mem_rdata;
        paste_CCR   = 1'b1;
        pipe_stall  = 1'b1;
      end
`ifdef RST_VECTOR_EN
      RST_VRD: begin
        mem_rd     = 1'b1;
        mem_addr   = RST_VEC_ADDR;
        pipe_stall = 1'b1;
      end
      RST_VLD: begin
        pc_load     = 1'b1;
        pc_load_val = mem_rdata;
        pipe_stall  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
